// File: rtl/cms_trace_receiver_if.sv
`default_nettype none
// ============================================================================
//  Module      : cms_trace_receiver_if
//  Description : AXI-Stream bundle (tvalid/tready/tdata/tlast) used for both
//                the wide trace input and the narrow beat output of
//                cms_trace_receiver.
//                master modport : drives tvalid/tdata/tlast, samples tready
//                slave  modport : samples tvalid/tdata/tlast, drives tready
//  Parameters  : DATA_WIDTH - width of tdata
//  Revision    : 1.0 - initial release
// ============================================================================
interface cms_trace_receiver_if #(
    parameter int DATA_WIDTH = 64
) ();
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (output tvalid, output tdata, output tlast, input  tready);
    modport slave  (input  tvalid, input  tdata, input  tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/cms_trace_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : cms_trace_receiver
//  Description : Consumes wide trace packets from continuous_monitoring_system,
//                decodes PC / instruction / clock delta, accumulates an
//                absolute clock count, checks tlast spacing and re-serialises
//                each packet LSB-first into OUT_WIDTH beats.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                S_AXIS (slave)    - wide packet input
//                M_AXIS (master)   - narrow beat output
//                tlast_interval    - expected packets per tlast burst (0 = off)
//                pkt_valid         - one-cycle pulse, decoded fields valid
//                pkt_pc/pkt_instr/pkt_clk_delta - decoded fields
//                pkt_clk_abs       - running sum of accepted deltas
//                pkt_count         - packets accepted since reset
//                tlast_error       - sticky tlast-spacing error
//  Config      : CMS_RECEIVER_TLAST_CHECK_EN - when defined, the gap counter
//                and tlast checker are built; otherwise tlast_error is 0 and
//                tlast_interval is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module cms_trace_receiver #(
    parameter int AXI_DATA_WIDTH             = 1024,
    parameter int OUT_WIDTH                  = 64,
    parameter int XLEN                       = 64,
    parameter int PC_LOCATION                = 805,
    parameter int CLK_COUNTER_DELTA_LOCATION = 869,
    parameter int CLK_COUNTER_WIDTH          = 64,
    parameter int INSTR_LOCATION             = 933
) (
    input  logic                         clk,
    input  logic                         rst,
    cms_trace_receiver_if.slave          S_AXIS,
    cms_trace_receiver_if.master         M_AXIS,
    input  logic [31:0]                  tlast_interval,
    output logic                         pkt_valid,
    output logic [XLEN-1:0]              pkt_pc,
    output logic [31:0]                  pkt_instr,
    output logic [CLK_COUNTER_WIDTH-1:0] pkt_clk_delta,
    output logic [CLK_COUNTER_WIDTH-1:0] pkt_clk_abs,
    output logic [31:0]                  pkt_count,
    output logic                         tlast_error
);

    localparam int c_N   = AXI_DATA_WIDTH / OUT_WIDTH;
    localparam int c_K_W = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_K_W-1:0] c_K_LAST = c_K_W'(c_N - 1);

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_SERIALIZE = 1'b1
    } state_t;

    state_t                         r_state;
    logic [c_K_W-1:0]               r_k;
    logic [AXI_DATA_WIDTH-1:0]      r_hold;
    logic                           r_hold_last;
    logic                           r_pkt_valid;
    logic [XLEN-1:0]                r_pc;
    logic [31:0]                    r_instr;
    logic [CLK_COUNTER_WIDTH-1:0]   r_delta;
    logic [CLK_COUNTER_WIDTH-1:0]   r_clk_abs;
    logic [31:0]                    r_count;

    logic                           w_serializing;
    logic                           w_last_beat;
    logic                           w_m_hs;
    logic                           w_s_tready;
    logic                           w_accept;
    logic [CLK_COUNTER_WIDTH-1:0]   w_in_delta;
    logic [OUT_WIDTH-1:0]           w_beats [c_N];

    // Held word viewed as an array of output beats, beat 0 = least significant.
    for (genvar gi = 0; gi < c_N; gi++) begin : g_beats
        assign w_beats[gi] = r_hold[gi*OUT_WIDTH +: OUT_WIDTH];
    end

    assign w_serializing = (r_state == ST_SERIALIZE);
    assign w_last_beat   = w_serializing && (r_k == c_K_LAST);
    assign w_m_hs        = w_serializing && M_AXIS.tready;
    // A new packet may be taken on the very cycle the last beat leaves, which
    // gives gap-free back-to-back packets.
    assign w_s_tready    = (r_state == ST_IDLE) || (w_last_beat && M_AXIS.tready);
    assign w_accept      = S_AXIS.tvalid && w_s_tready;
    assign w_in_delta    = S_AXIS.tdata[CLK_COUNTER_DELTA_LOCATION +: CLK_COUNTER_WIDTH];

    assign S_AXIS.tready = w_s_tready;
    assign M_AXIS.tvalid = w_serializing;
    assign M_AXIS.tdata  = w_beats[r_k];
    assign M_AXIS.tlast  = r_hold_last && w_last_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_k         <= '0;
            r_hold      <= '0;
            r_hold_last <= 1'b0;
            r_pkt_valid <= 1'b0;
            r_pc        <= '0;
            r_instr     <= '0;
            r_delta     <= '0;
            r_clk_abs   <= '0;
            r_count     <= '0;
        end else begin
            r_pkt_valid <= w_accept;
            if (w_accept) begin
                r_hold      <= S_AXIS.tdata;
                r_hold_last <= S_AXIS.tlast;
                r_k         <= '0;
                r_state     <= ST_SERIALIZE;
                r_pc        <= S_AXIS.tdata[PC_LOCATION +: XLEN];
                r_instr     <= S_AXIS.tdata[INSTR_LOCATION +: 32];
                r_delta     <= w_in_delta;
                r_clk_abs   <= r_clk_abs + w_in_delta;
                r_count     <= r_count + 32'd1;
            end else if (w_m_hs) begin
                if (w_last_beat) begin
                    r_state <= ST_IDLE;
                    r_k     <= '0;
                end else begin
                    r_k     <= r_k + c_K_W'(1);
                end
            end
        end
    end

`ifdef CMS_RECEIVER_TLAST_CHECK_EN
    logic [31:0] r_gap;
    logic        r_tlast_error;
    logic [31:0] w_gap_next;

    assign w_gap_next = r_gap + 32'd1;

    // r_gap counts packets since the last tlast; the packet being accepted is
    // packet number w_gap_next of the current burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gap         <= '0;
            r_tlast_error <= 1'b0;
        end else if (w_accept) begin
            if (S_AXIS.tlast) begin
                r_gap <= '0;
                if ((tlast_interval != 32'd0) && (w_gap_next != tlast_interval))
                    r_tlast_error <= 1'b1;
            end else begin
                r_gap <= w_gap_next;
                if ((tlast_interval != 32'd0) && (w_gap_next == tlast_interval))
                    r_tlast_error <= 1'b1;
            end
        end
    end

    assign tlast_error = r_tlast_error;
`else
    logic w_unused_tlast_interval;
    assign w_unused_tlast_interval = ^tlast_interval;
    assign tlast_error = 1'b0;
`endif

    assign pkt_valid     = r_pkt_valid;
    assign pkt_pc        = r_pc;
    assign pkt_instr     = r_instr;
    assign pkt_clk_delta = r_delta;
    assign pkt_clk_abs   = r_clk_abs;
    assign pkt_count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_cms_trace_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cms_trace_receiver
//  Description : Self-checking bench for cms_trace_receiver. A negedge monitor
//                keeps a scoreboard of expected output beats and decoded
//                fields, filled when a packet is accepted and drained on each
//                output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cms_trace_receiver;

    localparam int W  = 1024;
    localparam int OW = 64;
    localparam int NB = W / OW;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] tl_int = 32'd0;

    logic        pkt_valid;
    logic [63:0] pkt_pc;
    logic [31:0] pkt_instr;
    logic [63:0] pkt_clk_delta;
    logic [63:0] pkt_clk_abs;
    logic [31:0] pkt_count;
    logic        tlast_error;

    always #5 clk = ~clk;

    cms_trace_receiver_if #(.DATA_WIDTH(W))  s_if ();
    cms_trace_receiver_if #(.DATA_WIDTH(OW)) m_if ();

    cms_trace_receiver dut (
        .clk            (clk),
        .rst            (rst),
        .S_AXIS         (s_if),
        .M_AXIS         (m_if),
        .tlast_interval (tl_int),
        .pkt_valid      (pkt_valid),
        .pkt_pc         (pkt_pc),
        .pkt_instr      (pkt_instr),
        .pkt_clk_delta  (pkt_clk_delta),
        .pkt_clk_abs    (pkt_clk_abs),
        .pkt_count      (pkt_count),
        .tlast_error    (tlast_error)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard / reference model ----------------
    typedef struct {
        logic [63:0] d;
        logic        l;
    } beat_t;

    beat_t       q[$];
    logic [63:0] m_pc = '0, m_delta = '0, m_abs = '0;
    logic [31:0] m_instr = '0, m_count = '0, m_gap = '0;
    logic        m_pv = 1'b0, m_err = 1'b0;
    int          beats_done = 0;

    // Stimulus fields of the packet currently offered (set by the driver).
    logic [63:0] drv_pc, drv_delta;
    logic [31:0] drv_instr;

    always @(negedge clk) begin : mon
        logic  exp_sr;
        beat_t b;
        exp_sr = (q.size() == 0) || (q.size() == 1 && m_if.tready);
        check_val("s_tready", 64'(s_if.tready), 64'(exp_sr));
        check_val("m_tvalid", 64'(m_if.tvalid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            check_val("m_tdata", m_if.tdata, q[0].d);
            check_val("m_tlast", 64'(m_if.tlast), 64'(q[0].l));
        end
        check_val("pkt_valid", 64'(pkt_valid), 64'(m_pv));
        if (m_pv) begin
            check_val("pkt_pc", pkt_pc, m_pc);
            check_val("pkt_instr", 64'(pkt_instr), 64'(m_instr));
            check_val("pkt_clk_delta", pkt_clk_delta, m_delta);
        end
        check_val("pkt_clk_abs", pkt_clk_abs, m_abs);
        check_val("pkt_count", 64'(pkt_count), 64'(m_count));
        check_val("tlast_error", 64'(tlast_error), 64'(m_err));

        // advance the model to the state after the coming posedge
        if (rst) begin
            q.delete();
            m_pc = '0; m_delta = '0; m_abs = '0; m_instr = '0;
            m_count = '0; m_gap = '0; m_pv = 1'b0; m_err = 1'b0;
        end else begin
            if (q.size() != 0 && m_if.tready) begin
                void'(q.pop_front());
                beats_done++;
            end
            m_pv = 1'b0;
            if (s_if.tvalid && exp_sr) begin
                for (int i = 0; i < NB; i++) begin
                    b.d = s_if.tdata[i*OW +: OW];
                    b.l = s_if.tlast && (i == NB - 1);
                    q.push_back(b);
                end
                m_pv    = 1'b1;
                m_pc    = drv_pc;
                m_instr = drv_instr;
                m_delta = drv_delta;
                m_abs   = m_abs + drv_delta;
                m_count = m_count + 32'd1;
`ifdef CMS_RECEIVER_TLAST_CHECK_EN
                if (s_if.tlast) begin
                    if (tl_int != 0 && (m_gap + 32'd1) != tl_int) m_err = 1'b1;
                    m_gap = '0;
                end else begin
                    if (tl_int != 0 && (m_gap + 32'd1) == tl_int) m_err = 1'b1;
                    m_gap = m_gap + 32'd1;
                end
`endif
            end
        end
    end

    // ---------------- downstream ready pattern ----------------
    int rmode = 0;   // 0: always ready, 1: toggle, 2: random
    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1:       m_if.tready = ~m_if.tready;
                2:       m_if.tready = 1'($urandom_range(0, 1));
                default: m_if.tready = 1'b1;
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [63:0] pc, input logic [31:0] instr,
                        input logic [63:0] delta, input logic last);
        logic [W-1:0] p;
        bit           acc;
        for (int i = 0; i < W / 32; i++) p[i*32 +: 32] = $urandom;
        p[805 +: 64] = pc;
        p[869 +: 64] = delta;
        p[933 +: 32] = instr;
        drv_pc      = pc;
        drv_instr   = instr;
        drv_delta   = delta;
        s_if.tdata  = p;
        s_if.tlast  = last;
        s_if.tvalid = 1'b1;
        acc = 1'b0;
        for (int c = 0; c < 200 && !acc; c++) begin
            @(negedge clk);
            acc = s_if.tready;
            @(posedge clk);
            #1;
        end
        if (!acc) check_val("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle();
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 1000 && q.size() != 0; c++) @(posedge clk);
        @(posedge clk);
        #1;
        if (q.size() != 0) check_val("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tdata  = '0;
        drv_pc = '0; drv_instr = '0; drv_delta = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // single packet
        send(64'h8, 32'h0000_006f, 64'd5, 1'b0);
        idle();
        drain();
        check_val("single_abs", pkt_clk_abs, 64'd5);
        check_val("single_count", 64'(pkt_count), 64'd1);

        // three back-to-back packets
        do_reset();
        send(64'h100, 32'h0000_0013, 64'd5, 1'b0);
        send(64'h104, 32'h0010_0093, 64'd3, 1'b0);
        send(64'h108, 32'h0020_0113, 64'd7, 1'b0);
        idle();
        drain();
        check_val("b2b_abs", pkt_clk_abs, 64'd15);
        check_val("b2b_count", 64'(pkt_count), 64'd3);

        // downstream toggling 1/0, then random backpressure
        rmode = 1;
        for (int i = 0; i < 3; i++) send(64'(32'h2000 + 4 * i), 32'h1234_5678 + i, 64'(i + 1), 1'b0);
        idle();
        drain();
        rmode = 2;
        for (int i = 0; i < 3; i++) send(64'(32'h3000 + 4 * i), $urandom, 64'($urandom_range(0, 100)), 1'(i == 2));
        idle();
        drain();
        rmode = 0;

        // tlast spacing: correct bursts of 4
        tl_int = 32'd4;
        do_reset();
        for (int i = 1; i <= 8; i++) send(64'(i * 4), 32'h13, 64'd1, 1'(i % 4 == 0));
        idle();
        drain();
        check_val("tlast_ok", 64'(tlast_error), 64'd0);

        // tlast arriving early on packet 3
        do_reset();
        for (int i = 1; i <= 3; i++) send(64'(i * 4), 32'h13, 64'd1, 1'(i == 3));
        idle();
        drain();
`ifdef CMS_RECEIVER_TLAST_CHECK_EN
        check_val("tlast_bad", 64'(tlast_error), 64'd1);
`else
        check_val("tlast_bad", 64'(tlast_error), 64'd0);
`endif
        tl_int = 32'd0;

        // accumulator wrap
        do_reset();
        send(64'h40, 32'h6f, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        send(64'h44, 32'h6f, 64'd5, 1'b0);
        idle();
        drain();
        check_val("wrap_abs", pkt_clk_abs, 64'd3);

        // reset in the middle of serialisation
        send(64'h80, 32'h6f, 64'd9, 1'b1);
        idle();
        begin
            int target;
            target = beats_done + 6;
            for (int c = 0; c < 100 && beats_done < target; c++) @(posedge clk);
            if (beats_done < target) check_val("beat6_timeout", 64'(beats_done), 64'(target));
        end
        #1;
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        check_val("rst_s_tready", 64'(s_if.tready), 64'd1);
        check_val("rst_count", 64'(pkt_count), 64'd0);
        check_val("rst_abs", pkt_clk_abs, 64'd0);
        send(64'hC0, 32'h0000_0073, 64'd2, 1'b0);
        idle();
        drain();
        check_val("post_rst_abs", pkt_clk_abs, 64'd2);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
